led_sequencer: RTL and testbench



---
 rtl/led_sequencer.sv | 79 +++++++
 tb/tb_led_sequencer.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/led_sequencer.sv
// led_sequencer: timed off/red/green/blue code stepper with run/pause/step/stop; optional LED_PWM_EN duty gating
module led_sequencer #(
  parameter int TICK_DIV = 24000000,
  parameter bit SKIP_OFF = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       pause,
  input  logic       step,
  input  logic       dir,
`ifdef LED_PWM_EN
  input  logic [3:0] duty,
`endif
  output logic [1:0] code,
  output logic       busy,
  output logic       tick
);
  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);
  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [1:0] code_int, code_n, inc, adv;
  always_comb begin
    inc = dir ? code_int - 2'd1 : code_int + 2'd1;
    adv = (SKIP_OFF && inc == 2'd0) ? (dir ? 2'd3 : 2'd1) : inc;
    code_n = stop ? 2'd0 :
             state == IDLE ? (start ? (dir ? 2'd3 : 2'd1) : 2'd0) :
             state == RUN ? ((!pause && cnt == LAST) ? adv : code_int) :
             ((!start && !pause && step) ? adv : code_int);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      code_int <= 2'd0;
      busy <= 1'b0;
      tick <= 1'b0;
    end else begin
      code_int <= code_n;
      tick <= !stop && state == RUN && !pause && cnt == LAST;
      if (stop) begin
        state <= IDLE;
        cnt <= '0;
        busy <= 1'b0;
      end else begin
        case (state)
          IDLE: if (start) begin
            state <= RUN;
            cnt <= '0;
            busy <= 1'b1;
          end
          RUN: if (pause) state <= PAUSE;
               else cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
          PAUSE: if (start || pause) state <= RUN;
          default: state <= IDLE;
        endcase
      end
    end
  end
`ifdef LED_PWM_EN
  logic [3:0] pwm_cnt, pwm_n;
  assign pwm_n = pwm_cnt + 4'd1;
  // gate with the counter value that will be current when this code is visible
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt <= 4'd0;
      code <= 2'd0;
    end else begin
      pwm_cnt <= pwm_n;
      code <= (pwm_n < duty) ? code_n : 2'd0;
    end
  end
`else
  assign code = code_int;
`endif
endmodule

// File: tb/tb_led_sequencer.sv
// tb_led_sequencer: checks wrap and skip-off instances against a cycle model plus literal pins
module tb_led_sequencer;
  localparam int TD = 4;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, stop = 1'b0, pause = 1'b0, step = 1'b0, dir = 1'b0;
  logic [1:0] code0, code1;
  logic busy0, busy1, tick0, tick1;
  int errors = 0, checks = 0;
  bit chk_en = 1'b0;
  int st = 0, cnt = 0, c0 = 0, c1 = 0, tk = 0, pc = 0;
`ifdef LED_PWM_EN
  logic [3:0] duty = 4'd4;
`endif
  always #5 clk = ~clk;

  led_sequencer #(.TICK_DIV(TD), .SKIP_OFF(1'b0)) d0 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause), .step(step), .dir(dir),
`ifdef LED_PWM_EN
    .duty(duty),
`endif
    .code(code0), .busy(busy0), .tick(tick0));
  led_sequencer #(.TICK_DIV(TD), .SKIP_OFF(1'b1)) d1 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause), .step(step), .dir(dir),
`ifdef LED_PWM_EN
    .duty(duty),
`endif
    .code(code1), .busy(busy1), .tick(tick1));

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d at %0t", n, act, exp, $time);
    end
  endtask

  function automatic int shown(input int m);
`ifdef LED_PWM_EN
    return (pc < int'(duty)) ? m : 0;
`else
    return m;
`endif
  endfunction

  // model: mode 0 idle, 1 run, 2 pause; codes advance by modular arithmetic
  always @(posedge clk) begin
    if (rst) begin
      st = 0; cnt = 0; c0 = 0; c1 = 0; tk = 0; pc = 0;
    end else begin
      tk = 0;
      pc = (pc + 1) % 16;
      if (stop) begin
        st = 0; cnt = 0; c0 = 0; c1 = 0;
      end else if (st == 0) begin
        if (start) begin
          st = 1; cnt = 0; c0 = dir ? 3 : 1; c1 = c0;
        end
      end else if (st == 1) begin
        if (pause) st = 2;
        else if (cnt == TD - 1) begin
          cnt = 0; tk = 1;
          c0 = (c0 + (dir ? 3 : 1)) % 4;
          c1 = ((c1 - 1 + (dir ? 2 : 1)) % 3) + 1;
        end else cnt++;
      end else begin
        if (start || pause) st = 1;
        else if (step) begin
          c0 = (c0 + (dir ? 3 : 1)) % 4;
          c1 = ((c1 - 1 + (dir ? 2 : 1)) % 3) + 1;
        end
      end
    end
  end

  always @(negedge clk) if (chk_en) begin
    chk("d0_code", int'(code0), shown(c0));
    chk("d0_busy", int'(busy0), int'(st != 0));
    chk("d0_tick", int'(tick0), tk);
    chk("d1_code", int'(code1), shown(c1));
    chk("d1_busy", int'(busy1), int'(st != 0));
    chk("d1_tick", int'(tick1), tk);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic lit(input string n, input int e0, input int e1, input int et, input int eb);
    chk({n, "_c0"}, c0, e0);
    chk({n, "_c1"}, c1, e1);
    chk({n, "_tick"}, tk, et);
    chk({n, "_busy"}, int'(st != 0), eb);
  endtask

  initial begin
    cyc(1);
    chk_en = 1'b1;
    cyc(2);
    rst = 1'b0;
    repeat (10) begin cyc(1); lit("idle", 0, 0, 0, 0); end
    start = 1'b1; cyc(1); start = 1'b0;
    lit("load", 1, 1, 0, 1);
    cyc(3); lit("hold", 1, 1, 0, 1);
    cyc(1); lit("adv1", 2, 2, 1, 1);
    cyc(4); lit("adv2", 3, 3, 1, 1);
    cyc(4); lit("wrap", 0, 1, 1, 1);
    cyc(4); lit("adv4", 1, 2, 1, 1);
    cyc(2);
    pause = 1'b1; cyc(1); pause = 1'b0;
    cyc(20); lit("frozen", 1, 2, 0, 1);
    step = 1'b1; cyc(1); step = 1'b0;
    lit("step", 2, 3, 0, 1);
    start = 1'b1; cyc(1); start = 1'b0;
    lit("resume0", 2, 3, 0, 1);
    cyc(1); lit("resume1", 2, 3, 0, 1);
    cyc(1); lit("resume2", 3, 1, 1, 1);
    cyc(3);
    pause = 1'b1; cyc(1); pause = 1'b0;
    lit("pause_adv", 3, 1, 0, 1);
    start = 1'b1; cyc(1); start = 1'b0;
    cyc(1); lit("after", 0, 2, 1, 1);
    stop = 1'b1; start = 1'b1; cyc(1); stop = 1'b0; start = 1'b0;
    lit("stopstart", 0, 0, 0, 0);
    start = 1'b1; cyc(1); start = 1'b0;
    cyc(4); lit("c10", 2, 2, 1, 1);
    rst = 1'b1; cyc(1); rst = 1'b0;
    lit("rst_run", 0, 0, 0, 0);
    dir = 1'b1;
    start = 1'b1; cyc(1); start = 1'b0;
    lit("d_load", 3, 3, 0, 1);
    cyc(4); lit("d1", 2, 2, 1, 1);
    cyc(4); lit("d2", 1, 1, 1, 1);
    cyc(4); lit("d3", 0, 3, 1, 1);
    cyc(4); lit("d4", 3, 2, 1, 1);
    stop = 1'b1; cyc(1); stop = 1'b0;
    repeat (3000) begin
      rst = ($urandom_range(0, 499) == 0);
      start = ($urandom_range(0, 19) == 0);
      stop = ($urandom_range(0, 59) == 0);
      pause = ($urandom_range(0, 24) == 0);
      step = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 49) == 0) dir = ~dir;
      cyc(1);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
